spi_rw_3w: RTL and testbench

Parametrised 3-wire SPI register-access master for the ADC configuration port. It performs both register reads and register writes. Address width, data width and SCLK rate are set by parameters. The block drives a bidirectional SDIO line through separate out, enable and in signals, and captures read data. It sits between the board control logic (register start/done handshake) and the ADC CSB/SCLK/SDIO pins.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sclk_gen.sv | 52 +++++
 rtl/spi_rw_3w.sv | 202 ++++++++++++++++++++
 tb/tb_spi_rw_3w.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the 3-wire SPI register-access master.
package spi_pkg;

    // Frame sequencing states of the master.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Total bits in one frame: R/W bit, two width bits, address, data.
    function automatic int nbits(input int addr_w, input int data_w);
        return 3 + addr_w + data_w;
    endfunction

    // W1:W0 code telling the ADC how many data bytes follow (bytes - 1).
    function automatic logic [1:0] wbits(input int data_w);
        return 2'(data_w / 8 - 1);
    endfunction

    // Data width must be a whole number of bytes between one and four.
    function automatic bit data_w_ok(input int data_w);
        return (data_w == 8) || (data_w == 16) || (data_w == 24) || (data_w == 32);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: counts CLK_DIV clk cycles per half period while enabled.
// rise/fall are one-cycle strobes that are high in the cycle whose closing
// clk edge toggles sclk, so the caller can act on that very edge.
module spi_sclk_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          last;

    // Half-period counter; disabled means counter cleared and sclk parked low.
    always_comb begin
        last   = (cnt_q == CW'(CLK_DIV - 1));
        rise   = en && last && !sclk_q;
        fall   = en && last && sclk_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (last) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Counter and sclk registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_rw_3w.sv
// 3-wire SPI register read/write master for the ADC configuration port.
// Handshake: start is accepted only in a cycle where busy=0 (including the
// done cycle); busy then stays high until the one-cycle done pulse, and
// inputs presented while busy are ignored.
module spi_rw_3w
    import spi_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              csb,
    output logic              sclk,
    output logic              sdio_o,
    output logic              sdio_oe,
    input  logic              sdio_i,
    output spi_state_e        dbg_state
);

    localparam int NB  = nbits(ADDR_W, DATA_W);
    localparam int HDR = 3 + ADDR_W;
    localparam int BCW = $clog2(NB + 1);
    localparam int TCW = $clog2(2 * CLK_DIV + 1);

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("spi_rw_3w: DATA_W must be 8, 16, 24 or 32");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_rw_3w: CLK_DIV must be at least 1");
    end

    spi_state_e        state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]    tmr_q, tmr_d;
    logic [NB-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              rw_q, rw_d;
    logic              csb_q, csb_d;
    logic              sdio_o_q, sdio_o_d;
    logic              sdio_oe_q, sdio_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic sclk_en, sclk_rise, sclk_fall;

    assign sclk_en = (state_q == SHIFT);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Frame sequencing: next state, shift registers, pin values and handshake.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        csb_d     = csb_q;
        sdio_o_d  = sdio_o_q;
        sdio_oe_d = sdio_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;

        unique case (state_q)
            IDLE: begin
                csb_d     = 1'b1;
                sdio_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (start) begin
                    rw_d      = rw;
                    tx_d      = {rw, wbits(DATA_W), addr, wdata};
                    rx_d      = '0;
                    sdio_o_d  = rw;
                    csb_d     = 1'b0;
                    sdio_oe_d = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                    state_d   = LEAD;
                end
            end

            LEAD: begin
                if (tmr_q == TCW'(CLK_DIV - 1)) begin
                    tmr_d   = '0;
                    state_d = SHIFT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            SHIFT: begin
                // Read data is captured on the clk edge that raises sclk.
                if (sclk_rise && rw_q && (bit_cnt_q >= BCW'(HDR))) begin
                    rx_d = {rx_q[DATA_W-2:0], sdio_i};
                end
                // The next bit is presented on the edge that drops sclk.
                if (sclk_fall) begin
                    if (bit_cnt_q == BCW'(NB - 1)) begin
                        tmr_d   = '0;
                        state_d = TRAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = {tx_q[NB-2:0], 1'b0};
                        sdio_o_d  = tx_q[NB-2];
                        // Turn the line around before the first data bit of a read.
                        if (rw_q && (bit_cnt_q == BCW'(HDR - 1))) begin
                            sdio_oe_d = 1'b0;
                        end
                    end
                end
            end

            TRAIL: begin
                if (tmr_q == TCW'(CLK_DIV - 1)) begin
                    tmr_d     = '0;
                    csb_d     = 1'b1;
                    sdio_oe_d = 1'b0;
                    state_d   = GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            GAP: begin
                if (tmr_q == TCW'(2 * CLK_DIV - 1)) begin
                    tmr_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (rw_q) begin
                        rd_data_d = rx_q;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rw_q      <= 1'b0;
            csb_q     <= 1'b1;
            sdio_o_q  <= 1'b0;
            sdio_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            csb_q     <= csb_d;
            sdio_o_q  <= sdio_o_d;
            sdio_oe_q <= sdio_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign csb       = csb_q;
    assign sdio_o    = sdio_o_q;
    assign sdio_oe   = sdio_oe_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_rw_3w.sv
// Bench for spi_rw_3w: two instances (defaults, and DATA_W=16/CLK_DIV=3),
// each with a cycle-timeline model of the frame and an ADC responder.
module tb_spi_rw_3w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit fin0     = 1'b0;
    bit fin1     = 1'b0;

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int AW      = 13;
        localparam int DW      = (g == 0) ? 8 : 16;
        localparam int CD      = (g == 0) ? 1 : 3;
        localparam int NB      = 3 + AW + DW;
        localparam int HDR     = 3 + AW;
        localparam int SH_END  = CD + 2 * NB * CD;
        localparam int CSB_END = CD * (2 * NB + 2);
        localparam int LAST    = CD * (2 * NB + 4);

        // Hand-computed directed vectors and expectations.
        localparam logic [12:0] W_ADDR    = (g == 0) ? 13'h01A5 : 13'h00C3;
        localparam logic [15:0] W_DATA    = (g == 0) ? 16'h003C : 16'hBEEF;
        localparam logic [63:0] W_FRAME   = (g == 0) ? 64'h01A53C : 64'h20C3BEEF;
        localparam logic [12:0] R_ADDR    = (g == 0) ? 13'h0001 : 13'h0155;
        localparam logic [15:0] R_ADC     = (g == 0) ? 16'h00A7 : 16'h5AC3;
        localparam logic [15:0] R_HDR     = (g == 0) ? 16'h8001 : 16'hA155;
        localparam logic [15:0] R2_ADC    = (g == 0) ? 16'h005E : 16'h9E01;
        localparam int          EXP_LAT   = (g == 0) ? 53 : 205;
        localparam int          EXP_LOW   = (g == 0) ? 50 : 198;

        logic          rst, start, rw, sdio_i;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rd_data, adc_val;
        logic          busy, done, csb, sclk, sdio_o, sdio_oe;
        spi_pkg::spi_state_e dbg_state;

        spi_rw_3w #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(CD)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .rw        (rw),
            .addr      (addr),
            .wdata     (wdata),
            .busy      (busy),
            .done      (done),
            .rd_data   (rd_data),
            .csb       (csb),
            .sclk      (sclk),
            .sdio_o    (sdio_o),
            .sdio_oe   (sdio_oe),
            .sdio_i    (sdio_i),
            .dbg_state (dbg_state)
        );

        // Bits seen on sdio_o at each SCLK rise, as the ADC would sample them.
        logic [63:0] cap = '0;
        always @(posedge sclk) cap = {cap[62:0], sdio_o};

        // Timeline model: n = cycles since the start was accepted (0 = idle).
        int            n = 0;
        int            frames = 0;
        int            bi, mm;
        logic          m_rw = 1'b0;
        logic [NB-1:0] m_frame = '0;
        logic [DW-1:0] m_adc = '0;
        logic [DW-1:0] exp_rd = '0;
        logic          e_csb, e_sclk, e_oe, e_busy, e_done, in_shift;

        always @(negedge clk) begin
            if (rst) begin
                n      = 0;
                exp_rd = '0;
                chk("rst_csb", g, csb, 1'b1);
                chk("rst_sclk", g, sclk, 1'b0);
                chk("rst_sdio_o", g, sdio_o, 1'b0);
                chk("rst_sdio_oe", g, sdio_oe, 1'b0);
                chk("rst_busy", g, busy, 1'b0);
                chk("rst_done", g, done, 1'b0);
                chk("rst_rd_data", g, rd_data, '0);
                sdio_i = 1'b0;
            end else begin
                e_busy   = (n >= 1) && (n <= LAST);
                e_done   = (n == LAST + 1);
                e_csb    = !((n >= 1) && (n <= CSB_END));
                e_sclk   = 1'b0;
                in_shift = 1'b0;
                bi       = 0;
                if (n >= 1 && n <= CD) begin
                    bi = 0;
                end else if (n > CD && n <= SH_END) begin
                    mm       = n - CD - 1;
                    bi       = mm / (2 * CD);
                    e_sclk   = (mm % (2 * CD)) >= CD;
                    in_shift = 1'b1;
                end else if (n > SH_END && n <= CSB_END) begin
                    bi = NB - 1;
                end
                e_oe = m_rw ? ((n >= 1) && (n <= CD + HDR * 2 * CD)) : !e_csb;
                if (e_done && m_rw) exp_rd = m_adc;

                chk("csb", g, csb, e_csb);
                chk("sclk", g, sclk, e_sclk);
                chk("sdio_oe", g, sdio_oe, e_oe);
                chk("busy", g, busy, e_busy);
                chk("done", g, done, e_done);
                chk("rd_data", g, rd_data, exp_rd);
                if (e_oe) chk("sdio_o", g, sdio_o, m_frame[NB-1-bi]);

                // ADC side: present each read data bit for its whole period.
                if (in_shift && m_rw && bi >= HDR) sdio_i = m_adc[DW-1-(bi-HDR)];
                else sdio_i = 1'($urandom_range(0, 1));

                if (e_busy) begin
                    n = n + 1;
                end else if (start) begin
                    m_rw    = rw;
                    m_frame = {rw, 2'(DW / 8 - 1), addr, wdata};
                    m_adc   = adc_val;
                    frames  = frames + 1;
                    n       = 1;
                end else begin
                    n = 0;
                end
            end
        end

        // One complete frame: latency and csb-low time measured from the start cycle.
        task automatic run_frame(input logic f_rw, input logic [AW-1:0] f_addr, input logic [DW-1:0] f_wd,
                                 input logic [DW-1:0] f_adc, output int lat, output int low);
            @(posedge clk); #1;
            cap     = '0;
            rw      = f_rw;
            addr    = f_addr;
            wdata   = f_wd;
            adc_val = f_adc;
            start   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat   = 1;
            low   = csb ? 0 : 1;
            rw    = 1'($urandom);
            addr  = AW'($urandom);
            wdata = DW'($urandom);
            while (!done && lat < 2 * LAST) begin
                @(posedge clk); #1;
                lat++;
                if (!csb) low++;
                start = (lat == LAST / 2);
            end
            start = 1'b0;
            chk("done_seen", g, done, 1'b1);
        endtask

        int lat, low, dn, cyc, f0;

        initial begin
            rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; adc_val = '0; sdio_i = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            // Write frame: exact bit sequence, csb-low length and latency.
            run_frame(1'b0, W_ADDR[AW-1:0], W_DATA[DW-1:0], '0, lat, low);
            chk("wr_latency", g, lat, EXP_LAT);
            chk("wr_csb_low", g, low, EXP_LOW);
            chk("wr_bits", g, 64'(cap[NB-1:0]), W_FRAME);

            // Read frame: header bits and captured data.
            run_frame(1'b1, R_ADDR[AW-1:0], '0, R_ADC[DW-1:0], lat, low);
            chk("rd_latency", g, lat, EXP_LAT);
            chk("rd_header", g, cap[NB-1 -: 16], R_HDR);
            chk("rd_value", g, rd_data, R_ADC[DW-1:0]);

            // Write after read keeps the read value.
            run_frame(1'b0, 13'h1FFF, '1, '0, lat, low);
            chk("rd_held_after_write", g, rd_data, R_ADC[DW-1:0]);

            // start held high: three back-to-back frames, one done each.
            @(posedge clk); #1;
            rw = 1'b0; addr = 13'h0AAA; wdata = DW'(16'h5A5A); start = 1'b1;
            f0 = frames; dn = 0; cyc = 0;
            while (dn < 3 && cyc < 4 * EXP_LAT) begin
                @(posedge clk); #1;
                cyc++;
                if (done) dn++;
            end
            start = 1'b0;
            chk("b2b_dones", g, dn, 3);
            chk("b2b_cycles", g, cyc, 3 * EXP_LAT);
            @(negedge clk); #1;
            chk("b2b_frames_eq_dones", g, frames - f0, dn);

            // Reset in the middle of the address phase.
            @(posedge clk); #1;
            rw = 1'b0; addr = W_ADDR[AW-1:0]; wdata = W_DATA[DW-1:0]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (CD + 12 * CD) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("midrst_csb", g, csb, 1'b1);
            chk("midrst_sclk", g, sclk, 1'b0);
            chk("midrst_sdio_oe", g, sdio_oe, 1'b0);
            chk("midrst_rd_clear", g, rd_data, '0);
            dn = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            rst = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            chk("midrst_no_done", g, dn, 0);

            // Recovery: complete write then read.
            run_frame(1'b0, W_ADDR[AW-1:0], W_DATA[DW-1:0], '0, lat, low);
            chk("post_rst_wr_bits", g, 64'(cap[NB-1:0]), W_FRAME);
            chk("post_rst_wr_latency", g, lat, EXP_LAT);
            chk("post_rst_rd_zero", g, rd_data, '0);
            run_frame(1'b1, R_ADDR[AW-1:0], '0, R2_ADC[DW-1:0], lat, low);
            chk("post_rst_rd_value", g, rd_data, R2_ADC[DW-1:0]);

            repeat (3) @(posedge clk);
            if (g == 0) fin0 = 1'b1;
            else fin1 = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(fin0 && fin1) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("bench_complete", 0, {fin0, fin1}, 2'b11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
